// File: rtl/wb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : wb_lsu
// Brief    : Write-back stage load/store unit (req/gnt/rvalid data bus).
//            Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Revision : 1.0
// ============================================================================
module wb_lsu #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  input  logic                  write_en_i,
  input  logic [WORD_WIDTH-1:0] ex_data_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  output logic                  reg_we_o,
  output logic [ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [WORD_WIDTH-1:0] reg_wdata_o,
  output logic                  stall_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RWAIT = 2'd2
  } state_t;

  state_t r_state;

  logic                  w_is_load;
  logic                  w_is_store;
  logic                  w_op;
  logic                  w_misaligned;
  logic                  w_trap;
  logic                  w_active;
  logic                  w_req;
  logic                  w_completing;
  logic                  w_wb;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [WORD_WIDTH-1:0] w_load_data;

  assign w_is_load  = load_type_i inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
  assign w_is_store = ~w_is_load & (store_type_i != 2'b00);
  assign w_op       = w_is_load | w_is_store;

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_half_acc;
  logic w_word_acc;
  assign w_half_acc   = w_is_load ? (load_type_i[1:0] == 2'b10) : (store_type_i == 2'b10);
  assign w_word_acc   = w_is_load ? (load_type_i == 3'b011) : (store_type_i == 2'b11);
  assign w_misaligned = (w_half_acc & ex_data_i[0]) | (w_word_acc & (ex_data_i[1:0] != 2'b00));
`else
  // Low address bits are simply ignored for the access width (aligned down).
  assign w_misaligned = 1'b0;
`endif

  assign w_trap       = w_misaligned & w_op & (r_state == S_IDLE);
  assign w_active     = w_op & ~w_trap & ~rst_n;
  assign w_req        = w_active & (r_state != S_RWAIT);
  assign w_completing = (w_req & w_is_store & data_gnt_i) |
                        ((r_state == S_RWAIT) & data_rvalid_i);
  assign w_wb         = (r_state == S_RWAIT) & data_rvalid_i & w_is_load & ~rst_n;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_REQ: begin
          if (w_req) begin
            if (data_gnt_i) r_state <= w_is_load ? S_RWAIT : S_IDLE;
            else            r_state <= S_REQ;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RWAIT: begin
          if (data_rvalid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_req_o  = w_req;
  assign data_addr_o = {ex_data_i[WORD_WIDTH-1:2], 2'b00};
  assign data_we_o   = w_is_store;

  always_comb begin
    data_be_o    = 4'b1111;
    data_wdata_o = store_data_i;
    if (w_is_store) begin
      case (store_type_i)
        2'b01: begin
          data_be_o    = 4'b0001 << ex_data_i[1:0];
          data_wdata_o = {4{store_data_i[7:0]}};
        end
        2'b10: begin
          data_be_o    = ex_data_i[1] ? 4'b1100 : 4'b0011;
          data_wdata_o = {2{store_data_i[15:0]}};
        end
        default: begin
          data_be_o    = 4'b1111;
          data_wdata_o = store_data_i;
        end
      endcase
    end
  end

  always_comb begin
    w_byte = data_rdata_i[7:0];
    case (ex_data_i[1:0])
      2'b01:   w_byte = data_rdata_i[15:8];
      2'b10:   w_byte = data_rdata_i[23:16];
      2'b11:   w_byte = data_rdata_i[31:24];
      default: w_byte = data_rdata_i[7:0];
    endcase
    w_half = ex_data_i[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
    case (load_type_i)
      3'b001:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b010:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {24'd0, w_byte};
      3'b110:  w_load_data = {16'd0, w_half};
      default: w_load_data = data_rdata_i;
    endcase
  end

  // Non-memory ops bypass straight to the register file; loads write only on rvalid.
  assign reg_we_o     = w_wb ? write_en_i : (~w_op & ~rst_n & write_en_i);
  assign reg_waddr_o  = reg_waddr_i;
  assign reg_wdata_o  = w_op ? w_load_data : ex_data_i;
  assign stall_o      = w_active & ~w_completing;
  assign misaligned_o = w_trap & ~rst_n;

endmodule
`default_nettype wire

// File: tb/tb_wb_lsu.sv
`default_nettype none
// Testbench for wb_lsu: directed and randomized transactions checked against
// a width/offset arithmetic model of the load/store rules.
module tb_wb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic        write_en_i;
  logic [31:0] ex_data_i;
  logic [31:0] store_data_i;
  logic [4:0]  reg_waddr_i;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        stall_o;
  logic        misaligned_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_lsu #(.WORD_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_type_i(load_type_i), .store_type_i(store_type_i), .write_en_i(write_en_i),
    .ex_data_i(ex_data_i), .store_data_i(store_data_i), .reg_waddr_i(reg_waddr_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i),
    .reg_we_o(reg_we_o), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .stall_o(stall_o), .misaligned_o(misaligned_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_is_load(input logic [2:0] lt);
    return lt inside {3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
  endfunction

  function automatic int unsigned m_size(input logic [2:0] lt, input logic [1:0] st);
    if (m_is_load(lt)) return (lt[1:0] == 2'd1) ? 1 : (lt[1:0] == 2'd2) ? 2 : 4;
    return (st == 2'd1) ? 1 : (st == 2'd2) ? 2 : 4;
  endfunction

  task automatic idle_inputs();
    load_type_i   = 3'b000;
    store_type_i  = 2'b00;
    write_en_i    = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
  endtask

  // Drives one memory op (gnt after gd waits, rvalid after rvd waits) and checks each cycle.
  task automatic mem_op(input logic [2:0] lt, input logic [1:0] st, input logic we,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int gd, input int rvd);
    bit          ld;
    int unsigned sz, off;
    logic [31:0] mask, ebe, ewd, raw, ewb;
    logic [4:0]  wa;
    ld   = m_is_load(lt);
    sz   = m_size(lt, st);
    off  = (addr & ~(sz - 1)) % 4;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    ebe  = ((32'd1 << sz) - 1) << off;
    ewd  = (sz == 1) ? (sd & 32'hFF) * 32'h0101_0101 :
           (sz == 2) ? (sd & 32'hFFFF) * 32'h0001_0001 : sd;
    raw  = (rd >> (8 * off)) & mask;
    ewb  = raw;
    if ((lt == 3'b001 || lt == 3'b010) && raw >= (32'd1 << (8 * sz - 1)))
      ewb = raw - (32'd1 << (8 * sz));
    wa = 5'($urandom);
    load_type_i = lt; store_type_i = st; write_en_i = we;
    ex_data_i = addr; store_data_i = sd; reg_waddr_i = wa; data_rdata_i = rd;
`ifdef LSU_MISALIGN_TRAP_EN
    if (addr % sz != 0) begin
      data_gnt_i = 1'b1;
      @(negedge clk);
      chk("trap_req", data_req_o, 0);
      chk("trap_flag", misaligned_o, 1);
      chk("trap_stall", stall_o, 0);
      chk("trap_reg_we", reg_we_o, 0);
      @(posedge clk); #1;
      idle_inputs();
      return;
    end
`endif
    for (int c = 0; c <= gd; c++) begin
      data_gnt_i    = (c == gd);
      data_rvalid_i = (c < gd) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      chk("req", data_req_o, 1);
      chk("addr", data_addr_o, addr & 32'hFFFF_FFFC);
      chk("we", data_we_o, !ld);
      if (!ld) begin
        chk("be", data_be_o, ebe);
        chk("wdata", data_wdata_o, ewd);
      end
      chk("stall_req", stall_o, (ld || c < gd));
      chk("reg_we_req", reg_we_o, 0);
      chk("misaligned", misaligned_o, 0);
      @(posedge clk); #1;
    end
    data_gnt_i = 1'b0;
    if (ld) begin
      for (int c = 0; c <= rvd; c++) begin
        data_rvalid_i = (c == rvd);
        data_gnt_i    = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("req_rwait", data_req_o, 0);
        chk("stall_rwait", stall_o, (c < rvd));
        chk("reg_we_rwait", reg_we_o, (c == rvd) ? we : 1'b0);
        if (c == rvd) begin
          chk("load_wdata", reg_wdata_o, ewb);
          chk("load_waddr", reg_waddr_o, wa);
        end
        @(posedge clk); #1;
      end
    end
    idle_inputs();
  endtask

  task automatic nonmem(input logic [2:0] lt, input logic we, input logic [31:0] ex);
    load_type_i = lt; store_type_i = 2'b00; write_en_i = we; ex_data_i = ex;
    reg_waddr_i = 5'($urandom);
    data_gnt_i = 1'($urandom_range(0, 1)); data_rvalid_i = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("nm_reg_we", reg_we_o, we);
    chk("nm_reg_wdata", reg_wdata_o, ex);
    chk("nm_stall", stall_o, 0);
    chk("nm_req", data_req_o, 0);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    logic [2:0] lt;
    logic [1:0] st;
    rst_n = 1'b1;
    idle_inputs();
    ex_data_i = '0; store_data_i = '0; reg_waddr_i = '0; data_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req", data_req_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_reg_we", reg_we_o, 0);
    chk("rst_misaligned", misaligned_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;

    mem_op(3'b000, 2'b11, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    mem_op(3'b000, 2'b01, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 2, 0);
    mem_op(3'b001, 2'b00, 1'b1, 32'h202, 32'h0, 32'h0080_FF11, 0, 0);
    mem_op(3'b101, 2'b00, 1'b1, 32'h202, 32'h0, 32'h0080_FF11, 0, 0);
    mem_op(3'b010, 2'b00, 1'b1, 32'h002, 32'h0, 32'h8001_1234, 0, 2);
    mem_op(3'b011, 2'b11, 1'b1, 32'h101, 32'h1234_5678, 32'hCAFE_F00D, 1, 1);
    nonmem(3'b000, 1'b1, 32'h1357_9BDF);
    nonmem(3'b111, 1'b1, 32'h2468_ACE0);

    // Reset while waiting for read data; the late rvalid must be dropped.
    load_type_i = 3'b011; write_en_i = 1'b1; ex_data_i = 32'h300; data_gnt_i = 1'b1;
    @(negedge clk);
    chk("rstmid_stall", stall_o, 1);
    @(posedge clk); #1;
    data_gnt_i = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_reg_we", reg_we_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; idle_inputs(); data_rvalid_i = 1'b1;
    @(negedge clk);
    chk("late_rv_reg_we", reg_we_o, 0);
    chk("late_rv_stall", stall_o, 0);
    chk("late_rv_req", data_req_o, 0);
    @(posedge clk); #1;
    idle_inputs();
    mem_op(3'b000, 2'b10, 1'b0, 32'h406, 32'h0000_BEEF, 32'h0, 1, 0);

    for (int i = 0; i < 60; i++) begin
      lt = 3'($urandom_range(0, 7));
      st = 2'($urandom_range(0, 3));
      if (m_is_load(lt) || st != 2'b00)
        mem_op(lt, st, 1'($urandom), $urandom, $urandom, $urandom,
               int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      else
        nonmem(lt, 1'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_lsu.md
# wb_lsu

Write-back stage load/store unit. Consumes the EX→WB pipeline register outputs (load/store type, address, store data, destination register) and drives the data-memory request/grant/rvalid bus. It produces byte enables and lane-replicated store data, and sign/zero-extends load data into the register-file write port. While an access is outstanding it raises `stall_o`, which feeds the pipeline `stall_ctrl`.

## Interface
Parameters:
- `WORD_WIDTH`, 32, data and address width; the only supported value is 32.
- `ADDR_WIDTH`, 5, register-file address width.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-high (asserted = 1).
- `load_type_i`  in  3  000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU; other codes are treated as none.
- `store_type_i`  in  2  00 none, 01 SB, 10 SH, 11 SW.
- `write_en_i`  in  1  register write request from EX.
- `ex_data_i`  in  WORD_WIDTH  ALU result; this is the memory address for loads and stores.
- `store_data_i`  in  WORD_WIDTH  store source register value.
- `reg_waddr_i`  in  ADDR_WIDTH  destination register.
- `data_req_o`  out  1  bus request.
- `data_gnt_i`  in  1  bus grant.
- `data_rvalid_i`  in  1  read data valid.
- `data_addr_o`  out  WORD_WIDTH  word-aligned address, `{ex_data_i[31:2],2'b00}`.
- `data_we_o`  out  1  1 = store.
- `data_be_o`  out  4  byte enables.
- `data_wdata_o`  out  WORD_WIDTH  lane-replicated store data.
- `data_rdata_i`  in  WORD_WIDTH  read data.
- `reg_we_o`  out  1  register-file write enable.
- `reg_waddr_o`  out  ADDR_WIDTH  equal to `reg_waddr_i`.
- `reg_wdata_o`  out  WORD_WIDTH  write-back data.
- `stall_o`  out  1  hold the upstream pipeline.
- `misaligned_o`  out  1  misaligned-access flag (see Configuration).

## Operation
- A memory op is present when `load_type_i` is a valid load code or `store_type_i != 0`. If both are present, the load wins and the store is ignored.
- FSM states: IDLE, REQ, RWAIT.
  - IDLE, op present and aligned: `data_req_o = 1` in the same cycle. On gnt: a store completes; a load goes to RWAIT. Without gnt, go to REQ.
  - REQ: hold `data_req_o = 1` with all bus outputs stable until gnt. Store on gnt → IDLE; load on gnt → RWAIT.
  - RWAIT: `data_req_o = 0`. On `data_rvalid_i`: write back and go to IDLE.
- `stall_o = op_present & ~completing`, where completing is store&gnt or RWAIT&rvalid. Upstream holds its inputs stable while `stall_o = 1`.
- Stores:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{sd[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{sd[15:0]}}`.
  - SW: `be = 1111`, `wdata = sd`.
  - `data_we_o = 1` for stores and 0 for loads.
- Loads: select byte/half by `addr[1:0]` / `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. `reg_we_o = write_en_i` only in the rvalid cycle.
- Non-memory op: `reg_we_o = write_en_i`, `reg_wdata_o = ex_data_i`, combinationally, with no stall.
- `data_rvalid_i` outside RWAIT is ignored. `data_gnt_i` without a request is ignored.

## Timing
- Reset values: FSM = IDLE, `data_req_o = 0`, `stall_o = 0`, `reg_we_o = 0`, `misaligned_o = 0`. The bus address, data and enables are don't-care while `data_req_o = 0`.
- Latency:
  - Store with immediate gnt: 0 stall cycles.
  - Load with gnt at cycle 0 and rvalid at cycle 1: 1 stall cycle; write-back occurs in cycle 1.
  - Each extra gnt or rvalid wait cycle adds one stall cycle.
- Reset asserted mid-access: the next state is IDLE and `data_req_o` drops the following cycle. A late rvalid is discarded and no register write occurs.
- Back-to-back ops: a new op may issue in the cycle after completion, starting from IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0] = 1`, or LW/SW with `addr[1:0] != 0`, issues no request.
  - `misaligned_o = 1` for one cycle, `reg_we_o = 0`, `stall_o = 0`.
- Undefined:
  - Low address bits are forced to 0 for the access width (aligned down) and the access proceeds.
  - `misaligned_o` is tied to 0.

## Test plan
- SW `addr = 0x100`, `sd = 0xDEADBEEF`, gnt same cycle → `req = 1`, `we = 1`, `be = 1111`, `wdata = 0xDEADBEEF`, `stall_o = 0`.
- SB `addr = 0x103`, `sd = 0x000000A5`, gnt after 2 cycles → `be = 1000`, `wdata = 0xA5A5A5A5`, `stall_o = 1` for 2 cycles, bus outputs stable.
- LB `addr = 0x202`, rdata `0x0080FF11` → `reg_wdata = 0xFFFFFF80`. LBU at the same address → `0x00000080`. `reg_we_o` pulses only in the rvalid cycle.
- LH `addr = 0x2`, rdata `0x8001_1234`, gnt at cycle 0, rvalid at cycle 3 → `reg_wdata = 0xFFFF8001`, `stall_o = 1` for cycles 0–2.
- Reset asserted in RWAIT, rvalid the following cycle → no `reg_we_o`, FSM in IDLE, `stall_o = 0`.
- With `LSU_MISALIGN_TRAP_EN`: LW `addr = 0x101` → `data_req_o = 0`, `misaligned_o = 1` for one cycle, `reg_we_o = 0`. Without it: request at `0x100`, load completes normally.
